// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU normalize/round stage.
// Defaults describe binary64.
package fpu_pkg;

    localparam int K = 64;
    localparam int W = 11;
    localparam int T = 52;
    localparam int SW = T + 4;

    localparam int CARRY_B = T + 3;
    localparam int INT_B = T + 2;
    localparam int LSB_B = 2;
    localparam int GUARD_B = 1;
    localparam int ROUND_B = 0;

    localparam logic [W-1:0] EXP_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

endpackage

// File: rtl/fpu_normalizer_if.sv
// Operand-in / result-out handshake bundle of the normalizer.
// slave faces the normalizer, master faces adder and consumer.
interface fpu_normalizer_if;

    logic                        in_valid;
    logic                        in_ready;
    logic                        in_sign;
    logic [fpu_pkg::W-1:0]       in_exponent;
    logic [fpu_pkg::SW-1:0]      in_significand;
    logic                        in_sticky;
    logic                        out_valid;
    logic                        out_ready;
    logic [fpu_pkg::K-1:0]       out;
    logic                        overflow;
    logic                        inexact;

    modport slave (
        input  in_valid,
        input  in_sign,
        input  in_exponent,
        input  in_significand,
        input  in_sticky,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output overflow,
        output inexact
    );

    modport master (
        output in_valid,
        output in_sign,
        output in_exponent,
        output in_significand,
        output in_sticky,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  overflow,
        input  inexact
    );

endinterface

// File: rtl/fpu_rounder.sv
// Round-to-nearest-even on a normalized significand, with
// renormalization when the increment carries out of the integer bit.
module fpu_rounder
    import fpu_pkg::*;
(
    input  logic [SW-1:0] sig_i,
    input  logic          sticky_i,
    output logic [T:0]    sig_o,
    output logic          carry_o,
    output logic          inexact_o
);

    logic          lsb;
    logic          g;
    logic          r;
    logic          up;
    logic [T+1:0]  sum;

    always_comb begin
        lsb = sig_i[LSB_B];
        g = sig_i[GUARD_B];
        r = sig_i[ROUND_B] | sticky_i;
        up = g & (r | lsb);
        sum = sig_i[SW-1:2] + {{(T+1){1'b0}}, up};
        carry_o = sum[T+1];
        // a carry leaves 10.00..0, so dropping the low bit is exact
        sig_o = carry_o ? sum[T+1:1] : sum[T:0];
        inexact_o = g | r;
    end

endmodule

// File: rtl/fpu_normalizer.sv
// Bit-serial normalize, RNE round and IEEE-754 pack behind the adder.
// One left shift per NORM cycle; result held in DONE until taken.
module fpu_normalizer
    import fpu_pkg::*;
(
    input logic              clk,
    input logic              rst,
    fpu_normalizer_if.slave  bus
);

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    logic [W:0]      exp_q, exp_d;
    logic [SW-1:0]   sig_q, sig_d;
    logic            sticky_q, sticky_d;
    logic [K-1:0]    out_q, out_d;
    logic            ovf_q, ovf_d;
    logic            inx_q, inx_d;

    logic [T:0]      rnd_sig;
    logic            rnd_carry;
    logic            rnd_inx;
    logic [W:0]      exp_r;

    fpu_rounder u_rounder (
        .sig_i     (sig_q),
        .sticky_i  (sticky_q),
        .sig_o     (rnd_sig),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            sig_q    <= '0;
            sticky_q <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            sig_q    <= sig_d;
            sticky_q <= sticky_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            inx_q    <= inx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        sig_d    = sig_q;
        sticky_d = sticky_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        inx_d    = inx_q;
        exp_r    = exp_q + {{W{1'b0}}, rnd_carry};

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.in_sign;
                    exp_d    = {1'b0, bus.in_exponent};
                    sig_d    = bus.in_significand;
                    sticky_d = bus.in_sticky;
                    ovf_d    = 1'b0;
                    inx_d    = 1'b0;
                    if (bus.in_exponent == EXP_ONES) begin
                        out_d = {bus.in_sign, EXP_ONES,
                                 bus.in_significand[T+1:2]};
                        state_d = S_DONE;
                    end else if (bus.in_significand == '0 &&
                                 !bus.in_sticky) begin
                        out_d = {bus.in_sign, {(K-1){1'b0}}};
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (sig_q[CARRY_B]) begin
                    sig_d    = {1'b0, sig_q[SW-1:1]};
                    sticky_d = sticky_q | sig_q[0];
                    exp_d    = exp_q + (W+1)'(1);
                    state_d  = S_ROUND;
                end else if (sig_q[INT_B] || exp_q == (W+1)'(1)) begin
                    state_d = S_ROUND;
                end else begin
                    sig_d = {sig_q[SW-2:0], 1'b0};
                    exp_d = exp_q - (W+1)'(1);
                end
            end
            S_ROUND: begin
                inx_d = rnd_inx;
                // exp_r is one bit wider, so >= also catches 0x800
                if (exp_r >= {1'b0, EXP_ONES}) begin
                    out_d = {sign_q, EXP_ONES, {T{1'b0}}};
                    ovf_d = 1'b1;
                end else begin
                    out_d = {sign_q,
                             rnd_sig[T] ? exp_r[W-1:0] : {W{1'b0}},
                             rnd_sig[T-1:0]};
                    ovf_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out       = out_q;
    assign bus.overflow  = ovf_q;
    assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fpu_normalizer.sv
// Directed-vector bench for fpu_normalizer.
// Each task drives one scenario and checks its own results.
module tb_fpu_normalizer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fpu_normalizer_if bus ();

    fpu_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one operand, return latency and the result seen in DONE
    task automatic run_op(
        input  logic        sg,
        input  logic [10:0] e,
        input  logic [55:0] s,
        input  logic        st,
        input  bit          ack,
        output int          lat,
        output logic [63:0] o,
        output logic        ov,
        output logic        ix
    );
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_sign = sg;
        bus.in_exponent = e;
        bus.in_significand = s;
        bus.in_sticky = st;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        o = bus.out;
        ov = bus.overflow;
        ix = bus.inexact;
        if (ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out !== 64'h0) begin
            errors++;
            $display("FAIL rst_out: got %h want 0", bus.out);
        end
        checks++;
        if ({bus.overflow, bus.inexact} !== 2'b00) begin
            errors++;
            $display("FAIL rst_flags: got %b%b want 00",
                     bus.overflow, bus.inexact);
        end
    endtask

    task automatic test_carry;
        int lat; logic [63:0] o; logic ov, ix;
        run_op(1'b0, 11'h3FF, 56'd1 << 55, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL carry_lat: got %0d want 3", lat);
        end
        checks++;
        if (o !== 64'h4000000000000000) begin
            errors++;
            $display("FAIL carry_out: got %h want 4000000000000000", o);
        end
        checks++;
        if ({ov, ix} !== 2'b00) begin
            errors++;
            $display("FAIL carry_flags: got %b%b want 00", ov, ix);
        end
    endtask

    task automatic test_normalize;
        int lat; logic [63:0] o; logic ov, ix;
        run_op(1'b0, 11'h3FF, 56'd1 << 51, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (lat !== 6 || o !== 64'h3FC0000000000000) begin
            errors++;
            $display("FAIL norm3: got %h lat %0d want 3fc0000000000000 lat 6",
                     o, lat);
        end
        run_op(1'b0, 11'h001, 56'd1 << 53, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (lat !== 3 || o !== 64'h0008000000000000) begin
            errors++;
            $display("FAIL subnorm: got %h lat %0d want 0008000000000000 lat 3",
                     o, lat);
        end
        run_op(1'b0, 11'h003, 56'd1 << 51, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (lat !== 5 || o !== 64'h0008000000000000) begin
            errors++;
            $display("FAIL exp_floor: got %h lat %0d want 0008000000000000 lat 5",
                     o, lat);
        end
    endtask

    task automatic test_round_even;
        int lat; logic [63:0] o; logic ov, ix;
        run_op(1'b0, 11'h3FF, (56'd1 << 54) | 56'd2, 1'b0, 1'b1,
               lat, o, ov, ix);
        checks++;
        if (o !== 64'h3FF0000000000000 || ix !== 1'b1) begin
            errors++;
            $display("FAIL tie_even: got %h ix %b want 3ff0000000000000 ix 1",
                     o, ix);
        end
        run_op(1'b0, 11'h3FF, (56'd1 << 54) | 56'd6, 1'b0, 1'b1,
               lat, o, ov, ix);
        checks++;
        if (o !== 64'h3FF0000000000002 || ix !== 1'b1) begin
            errors++;
            $display("FAIL tie_odd: got %h ix %b want 3ff0000000000002 ix 1",
                     o, ix);
        end
        run_op(1'b0, 11'h3FF, (56'd1 << 54) | 56'd2, 1'b1, 1'b1,
               lat, o, ov, ix);
        checks++;
        if (o !== 64'h3FF0000000000001 || ix !== 1'b1) begin
            errors++;
            $display("FAIL sticky_up: got %h ix %b want 3ff0000000000001 ix 1",
                     o, ix);
        end
    endtask

    task automatic test_round_carry;
        int lat; logic [63:0] o; logic ov, ix;
        logic [55:0] ones;
        ones = (56'd1 << 54) - 56'd4;
        run_op(1'b0, 11'h3FF, (56'd1 << 54) | ones | 56'd2, 1'b0, 1'b1,
               lat, o, ov, ix);
        checks++;
        if (o !== 64'h4000000000000000 || {ov, ix} !== 2'b01) begin
            errors++;
            $display("FAIL rnd_carry: got %h %b%b want 4000000000000000 01",
                     o, ov, ix);
        end
        run_op(1'b0, 11'h001, ones | 56'd2, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (o !== 64'h0010000000000000 || {ov, ix} !== 2'b01) begin
            errors++;
            $display("FAIL sub_to_norm: got %h %b%b want 0010000000000000 01",
                     o, ov, ix);
        end
        run_op(1'b0, 11'h7FE, 56'd1 << 55, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (o !== 64'h7FF0000000000000 || {ov, ix} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_carry: got %h %b%b want 7ff0000000000000 10",
                     o, ov, ix);
        end
        run_op(1'b1, 11'h7FE, (56'd1 << 54) | ones | 56'd2, 1'b0, 1'b1,
               lat, o, ov, ix);
        checks++;
        if (o !== 64'hFFF0000000000000 || {ov, ix} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_round: got %h %b%b want fff0000000000000 11",
                     o, ov, ix);
        end
    endtask

    task automatic test_special;
        int lat; logic [63:0] o; logic ov, ix;
        run_op(1'b1, 11'h000, 56'd0, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (lat !== 1 || o !== 64'h8000000000000000 || {ov, ix} !== 2'b00) begin
            errors++;
            $display("FAIL neg_zero: got %h lat %0d want 8000000000000000 lat 1",
                     o, lat);
        end
        run_op(1'b0, 11'h7FF, 56'h8000000000001 << 2, 1'b1, 1'b1,
               lat, o, ov, ix);
        checks++;
        if (lat !== 1 || o !== 64'h7FF8000000000001 || {ov, ix} !== 2'b00) begin
            errors++;
            $display("FAIL nan_pass: got %h lat %0d want 7ff8000000000001 lat 1",
                     o, lat);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [63:0] o; logic ov, ix;
        run_op(1'b0, 11'h3FF, 56'd1 << 55, 1'b0, 1'b0, lat, o, ov, ix);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out !== 64'h4000000000000000 || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got %h rdy %b vld %b want 4000000000000000 0 1",
                         bus.out, bus.in_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy %b vld %b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_norm;
        int lat; logic [63:0] o; logic ov, ix;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_sign = 1'b0;
        bus.in_exponent = 11'h3FF;
        bus.in_significand = 56'd1 << 44;
        bus.in_sticky = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out !== 64'h0) begin
            errors++;
            $display("FAIL mid_rst: got rdy %b vld %b out %h want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.out);
        end
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_discard: got vld %b want 0", bus.out_valid);
        end
        run_op(1'b0, 11'h3FF, 56'd1 << 44, 1'b0, 1'b1, lat, o, ov, ix);
        checks++;
        if (lat !== 13 || o !== 64'h3F50000000000000) begin
            errors++;
            $display("FAIL norm10: got %h lat %0d want 3f50000000000000 lat 13",
                     o, lat);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exponent = '0;
        bus.in_significand = '0;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_carry();
        test_normalize();
        test_round_even();
        test_round_carry();
        test_special();
        test_backpressure();
        test_reset_mid_norm();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
